// File: rtl/tap_echo_mixer_pkg.sv
// Shared types and constants for the tap echo mixer (top, datapath and bench).
package tap_echo_mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_MUTE = 2'd3
   } state_e;

   localparam int SAMPLE_W        = 8;
   localparam int GAIN_W          = 3;
   localparam int SEL_W           = 2;
   localparam int PROD_W          = SAMPLE_W + GAIN_W;
   localparam int SUM_W           = PROD_W + 1;
   localparam int MUTE_CNT_W      = 8;
   localparam int MUTE_CYCLES_DEF = 31;
   localparam int GAIN_SHIFT_DEF  = 3;

endpackage

// File: rtl/tap_echo_mixer_dp.sv
// Two-stage multiply/shift/add datapath; define TAP_ECHO_MIXER_SAT_EN to
// saturate the sum at full scale, otherwise the sum wraps modulo 256.
module tap_echo_mixer_dp
   import tap_echo_mixer_pkg::*;
#(
   parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic [SAMPLE_W-1:0] dry_i,
   input  logic [SAMPLE_W-1:0] tap_i,
   input  logic [GAIN_W-1:0]   gain_i,
   output logic [SAMPLE_W-1:0] mix_o
);

   function automatic logic [SAMPLE_W-1:0] sat_sum(input logic [SUM_W-1:0] s);
`ifdef TAP_ECHO_MIXER_SAT_EN
      if (s > SUM_W'((1 << SAMPLE_W) - 1)) begin
         return '1;
      end
      return SAMPLE_W'(s);
`else
      return SAMPLE_W'(s);
`endif
   endfunction

   logic [PROD_W-1:0]   prod_full;
   logic [PROD_W-1:0]   prod_p1_d, prod_p1_q;
   logic [SAMPLE_W-1:0] dry_p1_q;
   logic [SUM_W-1:0]    sum_p1;
   logic [SAMPLE_W-1:0] mix_p2_d, mix_p2_q;

   assign prod_full = PROD_W'(tap_i) * PROD_W'(gain_i);
   assign prod_p1_d = prod_full >> GAIN_SHIFT;

   // stage 1: capture dry sample and scaled tap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dry_p1_q  <= '0;
         prod_p1_q <= '0;
      end else if (clr_i) begin
         dry_p1_q  <= '0;
         prod_p1_q <= '0;
      end else begin
         dry_p1_q  <= dry_i;
         prod_p1_q <= prod_p1_d;
      end
   end

   assign sum_p1   = SUM_W'(dry_p1_q) + SUM_W'(prod_p1_q);
   assign mix_p2_d = sat_sum(sum_p1);

   // stage 2: limited sum to the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_p2_q <= '0;
      end else if (clr_i) begin
         mix_p2_q <= '0;
      end else begin
         mix_p2_q <= mix_p2_d;
      end
   end

   assign mix_o = mix_p2_q;

endmodule

// File: rtl/tap_echo_mixer.sv
// Echo tap mixer top: IDLE/FILL/RUN/MUTE control, mute counter, datapath
// instance. Optional output saturation via TAP_ECHO_MIXER_SAT_EN.
module tap_echo_mixer
   import tap_echo_mixer_pkg::*;
#(
   parameter int MUTE_CYCLES = MUTE_CYCLES_DEF,
   parameter int GAIN_SHIFT  = GAIN_SHIFT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [SAMPLE_W-1:0] dry_in,
   input  logic [SAMPLE_W-1:0] tap_in,
   input  logic [SEL_W-1:0]    tap_sel,
   input  logic [GAIN_W-1:0]   gain,
   output logic [SAMPLE_W-1:0] mix_out,
   output logic                mix_valid,
   output logic                muting
);

   localparam logic [MUTE_CNT_W-1:0] MUTE_RELOAD = MUTE_CNT_W'(MUTE_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [MUTE_CNT_W-1:0]   mute_cnt_q, mute_cnt_d;
   logic                    fill_cnt_q, fill_cnt_d;
   logic                    pend_q, pend_d;
   logic [SEL_W-1:0]        tap_sel_q;
   logic                    sel_chg;
   logic [SAMPLE_W-1:0]     tap_eff;

   assign sel_chg = (tap_sel != tap_sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mute_cnt_q <= '0;
         fill_cnt_q <= 1'b0;
         pend_q     <= 1'b0;
         tap_sel_q  <= '0;
      end else begin
         state_q    <= state_d;
         mute_cnt_q <= mute_cnt_d;
         fill_cnt_q <= fill_cnt_d;
         pend_q     <= pend_d;
         tap_sel_q  <= tap_sel;
      end
   end

   // a selection change seen during FILL is remembered and turns RUN into MUTE
   always_comb begin
      state_d    = state_q;
      mute_cnt_d = mute_cnt_q;
      fill_cnt_d = fill_cnt_q;
      pend_d     = pend_q;
      if (!ena) begin
         state_d    = ST_IDLE;
         mute_cnt_d = '0;
         fill_cnt_d = 1'b0;
         pend_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_FILL;
               fill_cnt_d = 1'b0;
               pend_d     = 1'b0;
            end
            ST_FILL: begin
               if (fill_cnt_q) begin
                  fill_cnt_d = 1'b0;
                  pend_d     = 1'b0;
                  if (pend_q || sel_chg) begin
                     state_d    = ST_MUTE;
                     mute_cnt_d = MUTE_RELOAD;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  fill_cnt_d = 1'b1;
                  pend_d     = pend_q | sel_chg;
               end
            end
            ST_RUN: begin
               if (sel_chg) begin
                  state_d    = ST_MUTE;
                  mute_cnt_d = MUTE_RELOAD;
               end
            end
            ST_MUTE: begin
               if (sel_chg) begin
                  mute_cnt_d = MUTE_RELOAD;
               end else if (mute_cnt_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  mute_cnt_d = mute_cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign tap_eff   = (state_q == ST_MUTE) ? '0 : tap_in;
   assign mix_valid = (state_q == ST_RUN) || (state_q == ST_MUTE);
   assign muting    = (state_q == ST_MUTE);

   tap_echo_mixer_dp #(
      .GAIN_SHIFT(GAIN_SHIFT)
   ) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (~ena),
      .dry_i (dry_in),
      .tap_i (tap_eff),
      .gain_i(gain),
      .mix_o (mix_out)
   );

endmodule

// File: tb/tb_tap_echo_mixer.sv
// Directed bench for tap_echo_mixer: latency, saturation/wrap, mute, mute
// restart, FILL-time selection change, enable drop and asynchronous reset.
module tb_tap_echo_mixer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] dry_in;
   logic [7:0] tap_in;
   logic [1:0] tap_sel;
   logic [2:0] gain;
   logic [7:0] mix_out;
   logic       mix_valid;
   logic       muting;

   int checks = 0;
   int errors = 0;

   logic       mute_hist [0:79];
   logic       vld_hist  [0:79];
   logic [7:0] mix_hist  [0:79];
   int         n_mute;
   int         n_vld;

   tap_echo_mixer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .dry_in   (dry_in),
      .tap_in   (tap_in),
      .tap_sel  (tap_sel),
      .gain     (gain),
      .mix_out  (mix_out),
      .mix_valid(mix_valid),
      .muting   (muting)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b0;
      dry_in  = 8'd10;
      tap_in  = 8'd80;
      tap_sel = 2'd0;
      gain    = 3'd4;
      tick();
      tick();
      check_eq("rst_mix", mix_out, 0);
      check_eq("rst_valid", mix_valid, 0);
      check_eq("rst_muting", muting, 0);

      // release and enable: FILL, FILL, RUN
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();
      check_eq("fill1_valid", mix_valid, 0);
      tick();
      check_eq("fill2_valid", mix_valid, 0);
      check_eq("lat_mix", mix_out, 50);
      tick();
      check_eq("run_valid", mix_valid, 1);
      check_eq("run_mix", mix_out, 50);

      // gain change, zero gain passes dry through after two clocks
      gain = 3'd0;
      tick();
      check_eq("g0_lat1", mix_out, 50);
      tick();
      check_eq("g0_mix", mix_out, 10);
      dry_in = 8'd37;
      tick();
      tick();
      check_eq("g0_dry37", mix_out, 37);
      check_eq("g0_muting", muting, 0);

      // saturation / wrap
      dry_in = 8'd200;
      tap_in = 8'd255;
      gain   = 3'd7;
      tick();
      tick();
`ifdef TAP_ECHO_MIXER_SAT_EN
      check_eq("sat_mix", mix_out, 255);
`else
      check_eq("wrap_mix", mix_out, 167);
`endif
      dry_in = 8'd10;
      tap_in = 8'd80;
      gain   = 3'd4;
      tick();
      tick();
      check_eq("restore_mix", mix_out, 50);

      // mute on selection change
      tap_sel = 2'd2;
      for (int i = 0; i < 40; i++) begin
         tick();
         mute_hist[i] = muting;
         vld_hist[i]  = mix_valid;
         mix_hist[i]  = mix_out;
      end
      n_mute = 0;
      n_vld  = 0;
      for (int i = 0; i < 40; i++) begin
         if (mute_hist[i]) n_mute++;
         if (vld_hist[i])  n_vld++;
      end
      check_eq("mute_len", n_mute, 31);
      check_eq("mute_first", mute_hist[0], 1);
      check_eq("mute_last", mute_hist[30], 1);
      check_eq("mute_end", mute_hist[31], 0);
      check_eq("mute_valid", n_vld, 40);
      check_eq("mute_mix_lag", mix_hist[1], 50);
      check_eq("mute_mix_first", mix_hist[2], 10);
      check_eq("mute_mix_last", mix_hist[32], 10);
      check_eq("mute_mix_back", mix_hist[33], 50);

      // restart mute 20 cycles in
      tap_sel = 2'd1;
      for (int i = 0; i < 80; i++) begin
         tick();
         mute_hist[i] = muting;
         if (i == 19) tap_sel = 2'd3;
      end
      n_mute = 0;
      for (int i = 0; i < 80; i++) begin
         if (mute_hist[i]) n_mute++;
      end
      check_eq("restart_len", n_mute, 51);
      check_eq("restart_last", mute_hist[50], 1);
      check_eq("restart_end", mute_hist[51], 0);

      // enable drop during MUTE
      tap_sel = 2'd0;
      repeat (5) tick();
      check_eq("drop_pre_muting", muting, 1);
      ena = 1'b0;
      tick();
      check_eq("drop_valid", mix_valid, 0);
      check_eq("drop_mix", mix_out, 0);
      check_eq("drop_muting", muting, 0);
      ena = 1'b1;
      tick();
      check_eq("reen_fill1", mix_valid, 0);
      tick();
      check_eq("reen_fill2", mix_valid, 0);
      check_eq("reen_mix", mix_out, 50);
      tick();
      check_eq("reen_valid", mix_valid, 1);
      check_eq("reen_muting", muting, 0);

      // selection change during FILL lands in MUTE
      ena = 1'b0;
      tick();
      ena = 1'b1;
      tick();
      tap_sel = 2'd2;
      tick();
      check_eq("fillchg_valid", mix_valid, 0);
      tick();
      check_eq("fillchg_muting", muting, 1);
      check_eq("fillchg_vld", mix_valid, 1);

      // let the mute finish, then assert reset between edges
      repeat (40) tick();
      check_eq("pre_rst_muting", muting, 0);
      check_eq("pre_rst_mix", mix_out, 50);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_mix", mix_out, 0);
      check_eq("arst_valid", mix_valid, 0);
      check_eq("arst_muting", muting, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_fill", mix_valid, 0);
      tick();
      tick();
      check_eq("post_rst_valid", mix_valid, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
